// File: rtl/shift_pkg.sv
// Shared types and defaults for the serial shift-register link blocks.
// The PARITY state is only entered when SIPO_PARITY_EN is defined.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int SHIFT_WIDTH_DEF = 4;

endpackage

// File: rtl/sipo_shifter.sv
// Shift register and bit counter for the SIPO receiver. Bits enter at the MSB;
// done flags the edge that shifts in the last bit of a word.
module sipo_shifter #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             shift_en,
  input  logic             restart,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));
  assign done = shift_en & ~restart & last;
  // While shifting, the word includes the incoming bit; otherwise it is the held register.
  assign word = shift_en ? {in, sr[WIDTH-1:1]} : sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr <= {in, sr[WIDTH-1:1]};
      if (restart)   cnt <= CW'(1);
      else if (last) cnt <= '0;
      else           cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_reg_sipo_rx.sv
// Serial-in parallel-out receiver: frames LSB-first bits into WIDTH-bit words on a
// held valid/ready port. Define SIPO_PARITY_EN for a trailing even-parity bit.
// Handshake: q is consumed on any edge where q_valid and q_ready are both 1;
// q and q_valid never change while q_valid=1 and q_ready=0 (new words overrun).
module shift_reg_sipo_rx
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             ovr,
  input  logic             ovr_clr,
`ifdef SIPO_PARITY_EN
  output logic             parity_err,
`endif
  output state_t           dbg_state
);

  state_t           state, state_nxt;
  logic             shift_en, restart, done, complete;
  logic [WIDTH-1:0] word;
  logic             load_ok, overrun;

  // start restarts a frame from any state; plain bits only shift mid-frame.
  assign shift_en = in_valid & (start | (state == SHIFT));
  assign restart  = in_valid & start;

  sipo_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .shift_en (shift_en),
    .restart  (restart),
    .word     (word),
    .done     (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && start) state_nxt = SHIFT;
      end
      SHIFT: begin
`ifdef SIPO_PARITY_EN
        if (done) state_nxt = PARITY;
`else
        if (done) begin
          state_nxt = IDLE;
          complete  = 1'b1;
        end
`endif
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (in_valid && start) begin
          state_nxt = SHIFT;
        end else if (in_valid) begin
          state_nxt = IDLE;
          complete  = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign load_ok = complete & (~q_valid | q_ready);
  assign overrun = complete & q_valid & ~q_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (load_ok) begin
      q       <= word;
      q_valid <= 1'b1;
    end else if (q_valid && q_ready) begin
      q_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovr <= 1'b0;
    else if (overrun) ovr <= 1'b1;
    else if (ovr_clr) ovr <= 1'b0;
  end

`ifdef SIPO_PARITY_EN
  logic parity_bad;
  assign parity_bad = complete & ((^word) ^ in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            parity_err <= 1'b0;
    else if (parity_bad) parity_err <= 1'b1;
    else if (ovr_clr)    parity_err <= 1'b0;
  end
`endif

  assign qbar      = ~q;
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Bench for shift_reg_sipo_rx: directed frames, a vector table and random traffic
// checked against a frame-level model. Build with SIPO_PARITY_EN to cover parity.
module tb_shift_reg_sipo_rx;
  import shift_pkg::*;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in = 1'b0, in_valid = 1'b0, start = 1'b0, q_ready = 1'b0, ovr_clr = 1'b0;
  logic [W-1:0] q, qbar;
  logic         q_valid, ovr;
  logic         perr;
  state_t       dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  shift_reg_sipo_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_valid   (in_valid),
    .start      (start),
    .q          (q),
    .qbar       (qbar),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .ovr        (ovr),
    .ovr_clr    (ovr_clr),
`ifdef SIPO_PARITY_EN
    .parity_err (perr),
`endif
    .dbg_state  (dbg_state)
  );

`ifndef SIPO_PARITY_EN
  assign perr = 1'b0;
`endif

  // reference model: frame position and accumulated bits by position
  int           m_pos;
  logic [W-1:0] m_acc, m_q;
  logic         m_qv, m_ovr, m_perr;

  task automatic model_reset();
    m_pos = 0; m_acc = '0; m_q = '0; m_qv = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic model_step(input logic b, iv, st, rdy, clr);
    logic done, bad, ovr_set;
    done = 1'b0; bad = 1'b0;
    if (iv) begin
      if (st) begin
        m_acc = '0; m_acc[0] = b; m_pos = 1;
      end else if (m_pos > 0 && m_pos < W) begin
        m_acc[m_pos] = b;
        m_pos++;
        if (m_pos == W && !PAR) begin done = 1'b1; m_pos = 0; end
      end else if (m_pos == W) begin
        done = 1'b1; bad = (^m_acc) ^ b; m_pos = 0;
      end
    end
    ovr_set = done && m_qv && !rdy;
    if (done && (!m_qv || rdy)) begin m_q = m_acc; m_qv = 1'b1; end
    else if (m_qv && rdy) m_qv = 1'b0;
    if (ovr_set) m_ovr = 1'b1; else if (clr) m_ovr = 1'b0;
    if (done && bad) m_perr = 1'b1; else if (clr) m_perr = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [W-1:0] nq;
    nq = ~m_q;
    chk("m_q", q, m_q);
    chk("m_qbar", qbar, nq);
    chk("m_q_valid", q_valid, m_qv);
    chk("m_ovr", ovr, m_ovr);
    chk("m_parity_err", perr, m_perr);
  endtask

  // driver tasks
  task automatic cycle(input logic b, iv, st, rdy, clr);
    in = b; in_valid = iv; start = st; q_ready = rdy; ovr_clr = clr;
    @(posedge clk);
    model_step(b, iv, st, rdy, clr);
    #1;
    compare_model();
  endtask

  // ftl lists the data bits first-sent first (ftl[3] is bit 0 of the word)
  task automatic send_frame(input logic [W-1:0] ftl, input logic rdy, input logic bad_par);
    for (int i = W - 1; i >= 0; i--) cycle(ftl[i], 1'b1, i == W - 1, rdy, 1'b0);
    if (PAR) cycle((^ftl) ^ bad_par, 1'b1, 1'b0, rdy, 1'b0);
  endtask

  typedef struct packed {
    logic [W-1:0] ftl;
    logic [W-1:0] exp_q;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{4'b1111, 4'b1111};
    vecs[1] = '{4'b0000, 4'b0000};
    vecs[2] = '{4'b1000, 4'b0001};
    vecs[3] = '{4'b0001, 4'b1000};
    vecs[4] = '{4'b1010, 4'b0101};
    vecs[5] = '{4'b0110, 4'b0110};
    vecs[6] = '{4'b1100, 4'b0011};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_q", q, 4'b0000);
    chk("rst_qbar", qbar, 4'b1111);
    chk("rst_q_valid", q_valid, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_parity_err", perr, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b1;
    @(negedge clk);

    // basic frame 1,1,0,1
    send_frame(4'b1101, 1'b0, 1'b0);
    chk("basic_q", q, 4'b1011);
    chk("basic_qbar", qbar, 4'b0100);
    chk("basic_q_valid", q_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_consume", q_valid, 1'b0);

    // back-to-back with q_ready held
    send_frame(4'b1101, 1'b1, 1'b0);
    chk("b2b_q1", q, 4'b1011);
    send_frame(4'b0110, 1'b1, 1'b0);
    chk("b2b_q2", q, 4'b0110);
    chk("b2b_q_valid", q_valid, 1'b1);
    chk("b2b_ovr", ovr, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // overrun and clear
    send_frame(4'b1101, 1'b0, 1'b0);
    send_frame(4'b1000, 1'b0, 1'b0);
    chk("ovr_q_held", q, 4'b1011);
    chk("ovr_set", ovr, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", ovr, 1'b0);
    chk("ovr_q_valid", q_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // aborted partial frame
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_state", dbg_state, SHIFT);
    send_frame(4'b0011, 1'b1, 1'b0);
    chk("abort_q", q, 4'b1100);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset mid-frame
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("midrst_q_valid", q_valid, 1'b0);
    chk("midrst_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_no_early", q_valid, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    if (PAR) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_q", q, 4'b1010);
    chk("midrst_q_valid2", q_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_PARITY_EN
    send_frame(4'b1101, 1'b1, 1'b0);
    chk("par_good_q", q, 4'b1011);
    chk("par_good_err", perr, 1'b0);
    send_frame(4'b1101, 1'b1, 1'b1);
    chk("par_bad_err", perr, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("par_clr", perr, 1'b0);
`endif

    // vector table
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].ftl, 1'b1, 1'b0);
      chk("vec_q", q, vecs[i].exp_q);
      chk("vec_q_valid", q_valid, 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic b, iv, st, rdy, clr;
      b   = 1'($urandom_range(0, 1));
      iv  = ($urandom_range(0, 9) < 7);
      st  = ($urandom_range(0, 9) < 2);
      rdy = ($urandom_range(0, 9) < 5);
      clr = ($urandom_range(0, 9) < 1);
      cycle(b, iv, st, rdy, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/shift_reg_sipo_rx.md
# shift_reg_sipo_rx

Serial-in, parallel-out receiver: the far end of the team's parallel-load shift-register link. It reassembles a framed serial bit stream into WIDTH-bit words and presents each completed word on a held valid/ready output port. Bits arrive LSB-first, and each new bit enters at the MSB and shifts right, mirroring the transmitter's shift direction. The block sits between the serial link pins and the parallel consumer logic.

## Interface
- WIDTH, 4, data word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in  input  1  serial data bit.
- in_valid  input  1  `in` carries a bit this cycle.
- start  input  1  qualified by in_valid; marks the current bit as bit 0 of a new frame.
- q  output  WIDTH  last completed word.
- qbar  output  WIDTH  always ~q (combinational).
- q_valid  output  1  q holds an unconsumed word.
- q_ready  input  1  consumer accepts q this cycle.
- ovr  output  1  sticky overrun flag.
- ovr_clr  input  1  clears ovr.
- parity_err  output  1  sticky parity error flag; exists only with SIPO_PARITY_EN.

## Operation
- Internal state: shift register sr[WIDTH-1:0], bit counter cnt (width clog2(WIDTH+1)), and an FSM.
- FSM states: IDLE, SHIFT, and PARITY (PARITY only with the macro).
- A bit is accepted only when in_valid=1. On each accepted bit: sr <= {in, sr[WIDTH-1:1]}.
- IDLE:
  - in_valid & start: accept the bit, cnt=1, go to SHIFT.
  - in_valid without start: bit is ignored.
- SHIFT:
  - in_valid & start: abort the partial frame; the bit restarts the frame as bit 0, cnt=1.
  - in_valid otherwise: accept the bit, cnt+1.
  - When the accepted bit is the WIDTH-th (cnt==WIDTH-1 before the edge), the word is complete. Go to IDLE, or to PARITY with the macro.
- On word completion, the word is {in, sr[WIDTH-1:1]}:
  - If q_valid=0, or q_valid=1 with q_ready=1 this cycle: q <= word, q_valid <= 1.
  - If q_valid=1 and q_ready=0: the word is dropped, q is unchanged, ovr <= 1.
- q_valid clears on q_valid & q_ready unless a new word loads in the same cycle; in that case q_valid stays 1.
- ovr_clr=1 clears ovr. If ovr_clr and a new overrun occur in the same cycle, set wins.
- Reset values: sr=0, cnt=0, FSM=IDLE, q=0, qbar=all ones, q_valid=0, ovr=0, parity_err=0.
- Reset asserted mid-frame discards the partial word immediately; no output is produced for it.

## Timing
- Latency: the final data bit is sampled at edge N; q and q_valid are updated after edge N. With the macro, they update after the edge that samples the parity bit.
- Minimum frame period is WIDTH cycles, or WIDTH+1 with parity. Back-to-back frames are supported (start on the cycle after completion).
- A q_ready held high sustains full throughput with no overrun.
- qbar follows q combinationally, with zero added latency.
- Idle cycles (in_valid=0) inside a frame are allowed. State holds.

## Configuration
- SIPO_PARITY_EN defined:
  - After the WIDTH-th data bit the FSM enters PARITY. The next accepted bit is an even-parity bit over the word.
  - The word loads to q at that edge, under the same overrun rules.
  - If the XOR of the data bits and the parity bit is 1, parity_err <= 1 (sticky; cleared by ovr_clr).
  - start on the parity cycle aborts the frame and restarts it; no word is produced.
- SIPO_PARITY_EN undefined: no PARITY state and no parity_err port. Frames are exactly WIDTH bits.

## Structure
- Shared package shift_pkg holds:
  - The FSM state enum (IDLE, SHIFT, PARITY).
  - The default width constant SHIFT_WIDTH_DEF = 4.
- One sub-module, sipo_shifter: sr plus cnt, with shift-enable, restart and done outputs.
- The top level holds the FSM, the output register and handshake, and the flags.

## Test plan
- Reset, then send start plus bits 1,1,0,1 on consecutive cycles -> q=1011, qbar=0100 and q_valid=1 after the 4th edge. q_ready=1 clears q_valid.
- Two back-to-back frames 1011 then 0110, q_ready held 1 -> q_valid stays 1, q goes 1011 then 0110, ovr=0.
- Frame 1011 with q_ready=0, then frame 0001 -> q stays 1011 and ovr=1. ovr_clr pulse -> ovr=0.
- Send 2 bits, then start plus 0,0,1,1 -> q=1100; the partial frame is discarded.
- Assert rst mid-frame after 2 bits, release, send a full frame of 0,1,0,1 -> q=1010, with no spurious q_valid before it.
- With SIPO_PARITY_EN: data 1,1,0,1 plus parity 1 -> q=1011, parity_err=0. Data 1,1,0,1 plus parity 0 -> parity_err=1.
